// File: rtl/dictionary_sequencer_if.sv
// Handshake bundle between the dictionary sequencer, its value/id sources, the
// dictionary datapath and the result stream it monitors.
interface dictionary_sequencer_if #(
   parameter int NUM_ELEMENTS = 8,
   parameter int CNT_W        = 13
);
   logic                    cfg_valid;
   logic                    cfg_ready;
   logic [CNT_W-1:0]        cfg_num_values;
   logic                    cfg_reload;

   logic                    src_val_valid;
   logic                    src_val_ready;
   logic [NUM_ELEMENTS-1:0] src_val_keep;
   logic                    src_val_last;
   logic                    dict_val_valid;
   logic                    dict_val_ready;

   logic                    src_id_valid;
   logic                    src_id_ready;
   logic                    src_id_last;
   logic                    dict_id_valid;
   logic                    dict_id_ready;

   logic                    res_valid;
   logic                    res_ready;
   logic                    res_last;

   modport master (
      output cfg_valid, cfg_num_values, cfg_reload,
      input  cfg_ready,
      output src_val_valid, src_val_keep, src_val_last,
      input  src_val_ready,
      input  dict_val_valid,
      output dict_val_ready,
      output src_id_valid, src_id_last,
      input  src_id_ready,
      input  dict_id_valid,
      output dict_id_ready,
      output res_valid, res_ready, res_last
   );

   modport slave (
      input  cfg_valid, cfg_num_values, cfg_reload,
      output cfg_ready,
      input  src_val_valid, src_val_keep, src_val_last,
      output src_val_ready,
      output dict_val_valid,
      input  dict_val_ready,
      input  src_id_valid, src_id_last,
      output src_id_ready,
      output dict_id_valid,
      input  dict_id_ready,
      input  res_valid, res_ready, res_last
   );
endinterface

// File: rtl/dictionary_sequencer.sv
// Load/probe phase controller for the dictionary datapath; gates handshakes only.
// Optional feature macro: DICT_SEQ_REPROBE_EN (keeps dictionary contents for probe-only jobs).
//
// state  | meaning
// IDLE   | no dictionary loaded, waiting for a reload job
// LOAD   | value stream routed to the datapath, counting lanes
// PROBE  | id stream routed to the datapath under the in-transit credit limit
// DRAIN  | ids finished, waiting for the final result beat
// LOADED | dictionary valid, accepts reload or probe-only jobs
module dictionary_sequencer #(
   parameter  int NUM_ELEMENTS   = 8,
   parameter  int MAX_ENTRIES    = 4096,
   parameter  int MAX_IN_TRANSIT = 64,
   localparam int CNT_W          = $clog2(MAX_ENTRIES + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   dictionary_sequencer_if.slave bus,
   output logic [2:0]           state,
   output logic [CNT_W-1:0]     loaded_count,
   output logic                 done,
   output logic                 err_count,
   output logic                 err_overflow,
   output logic                 err_underrun
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_PROBE  = 3'd2,
      S_DRAIN  = 3'd3,
      S_LOADED = 3'd4
   } state_t;

   localparam int OUT_W = $clog2(MAX_IN_TRANSIT + 1);
   localparam int POP_W = $clog2(NUM_ELEMENTS + 1);
   localparam logic [CNT_W:0]     MAX_SUM    = (CNT_W+1)'(MAX_ENTRIES);
   localparam logic [CNT_W-1:0]   MAX_COUNT  = CNT_W'(MAX_ENTRIES);
   localparam logic [OUT_W-1:0]   CREDIT_MAX = OUT_W'(MAX_IN_TRANSIT);

`ifdef DICT_SEQ_REPROBE_EN
   localparam state_t S_EXIT = S_LOADED;
`else
   localparam state_t S_EXIT = S_IDLE;
`endif

   state_t             state_q;
   logic [CNT_W-1:0]   num_values_q;
   logic [OUT_W-1:0]   outstanding_q;
   logic [OUT_W-1:0]   outstanding_nxt;
   logic               credit_ok;
   logic               cfg_acc;
   logic               val_acc;
   logic               id_acc;
   logic               res_acc;
   logic [POP_W-1:0]   keep_pop;
   logic [CNT_W:0]     load_sum;
   logic [CNT_W-1:0]   load_final;
   logic               load_ovf;

   function automatic logic [POP_W-1:0] popcount(input logic [NUM_ELEMENTS-1:0] v);
      logic [POP_W-1:0] c;
      c = '0;
      for (int i = 0; i < NUM_ELEMENTS; i++) c = c + POP_W'(v[i]);
      return c;
   endfunction

   // Gating is purely combinational off the registered state so no latency is added.
   always_comb begin
      bus.cfg_ready      = (state_q == S_IDLE) || (state_q == S_LOADED);
      credit_ok          = outstanding_q < CREDIT_MAX;
      bus.dict_val_valid = (state_q == S_LOAD) && bus.src_val_valid;
      bus.src_val_ready  = (state_q == S_LOAD) && bus.dict_val_ready;
      bus.dict_id_valid  = (state_q == S_PROBE) && credit_ok && bus.src_id_valid;
      bus.src_id_ready   = (state_q == S_PROBE) && credit_ok && bus.dict_id_ready;

      cfg_acc = bus.cfg_valid && bus.cfg_ready;
      val_acc = bus.src_val_valid && bus.src_val_ready;
      id_acc  = bus.src_id_valid && bus.src_id_ready;
      res_acc = bus.res_valid && bus.res_ready;

      keep_pop   = popcount(bus.src_val_keep);
      load_sum   = {1'b0, loaded_count} + (CNT_W+1)'(keep_pop);
      load_ovf   = load_sum > MAX_SUM;
      load_final = load_ovf ? MAX_COUNT : load_sum[CNT_W-1:0];

      outstanding_nxt = outstanding_q;
      if (id_acc && !res_acc)
         outstanding_nxt = outstanding_q + OUT_W'(1);
      else if (res_acc && !id_acc && (outstanding_q != '0))
         outstanding_nxt = outstanding_q - OUT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         num_values_q  <= '0;
         outstanding_q <= '0;
         loaded_count  <= '0;
         done          <= 1'b0;
         err_count     <= 1'b0;
         err_overflow  <= 1'b0;
         err_underrun  <= 1'b0;
      end else begin
         done          <= 1'b0;
         outstanding_q <= outstanding_nxt;
         case (state_q)
            S_IDLE, S_LOADED: begin
               if (cfg_acc) begin
                  err_count    <= 1'b0;
                  err_overflow <= 1'b0;
                  err_underrun <= 1'b0;
                  if (bus.cfg_reload) begin
                     loaded_count <= '0;
                     num_values_q <= bus.cfg_num_values;
                     state_q      <= S_LOAD;
                  end
`ifdef DICT_SEQ_REPROBE_EN
                  else if (state_q == S_LOADED) begin
                     state_q <= S_PROBE;
                  end
`endif
                  else begin
                     err_count <= 1'b1;
                  end
               end
            end
            S_LOAD: begin
               if (val_acc) begin
                  loaded_count <= load_final;
                  if (load_ovf) err_overflow <= 1'b1;
                  if (bus.src_val_last) begin
                     state_q <= S_PROBE;
                     if (load_final != num_values_q) err_count <= 1'b1;
                  end
               end
            end
            S_PROBE: begin
               if (id_acc && bus.src_id_last) begin
                  // A final result landing with the final id skips DRAIN entirely.
                  if (res_acc && bus.res_last) begin
                     done    <= 1'b1;
                     state_q <= S_EXIT;
                     if (outstanding_nxt != '0) err_count <= 1'b1;
                  end else begin
                     state_q <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               if (res_acc && bus.res_last) begin
                  done    <= 1'b1;
                  state_q <= S_EXIT;
                  if (outstanding_nxt != '0) err_count <= 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
         // Placed after the case so it is not masked by the cfg-time clear.
         if (res_acc && (outstanding_q == '0)) err_underrun <= 1'b1;
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_dictionary_sequencer.sv
// Directed bench for dictionary_sequencer with a scoreboard of expected job results.
// Expectations follow DICT_SEQ_REPROBE_EN when the bench is built with it.
module tb_dictionary_sequencer;

   localparam int NE    = 8;
   localparam int ME    = 32;
   localparam int MIT   = 4;
   localparam int CNT_W = $clog2(ME + 1);

`ifdef DICT_SEQ_REPROBE_EN
   localparam int EXIT_ST = 4;
`else
   localparam int EXIT_ST = 0;
`endif

   typedef struct {
      int st;
      int cnt;
      bit errc;
      bit ovf;
      bit und;
   } exp_t;

   logic             clk;
   logic             rst;
   logic [2:0]       state;
   logic [CNT_W-1:0] loaded_count;
   logic             done;
   logic             err_count;
   logic             err_overflow;
   logic             err_underrun;

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t exp_q[$];

   dictionary_sequencer_if #(.NUM_ELEMENTS(NE), .CNT_W(CNT_W)) bus ();

   dictionary_sequencer #(
      .NUM_ELEMENTS   (NE),
      .MAX_ENTRIES    (ME),
      .MAX_IN_TRANSIT (MIT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .state        (state),
      .loaded_count (loaded_count),
      .done         (done),
      .err_count    (err_count),
      .err_overflow (err_overflow),
      .err_underrun (err_underrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_tests++;
      assert (obs === want) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_pop(input string tag);
      exp_t e;
      chk({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk({tag, "_state"},        32'(state),        32'(e.st));
         chk({tag, "_loaded_count"}, 32'(loaded_count), 32'(e.cnt));
         chk({tag, "_err_count"},    32'(err_count),    32'(e.errc));
         chk({tag, "_err_overflow"}, 32'(err_overflow), 32'(e.ovf));
         chk({tag, "_err_underrun"}, 32'(err_underrun), 32'(e.und));
      end
   endtask

   task automatic do_cfg(input int num, input logic reload);
      bus.cfg_valid      = 1'b1;
      bus.cfg_num_values = CNT_W'(num);
      bus.cfg_reload     = reload;
      #1;
      chk("cfg_ready", 32'(bus.cfg_ready), 1);
      tick();
      bus.cfg_valid = 1'b0;
   endtask

   task automatic load_beats(input int nbeats, input logic [NE-1:0] last_keep);
      for (int b = 0; b < nbeats; b++) begin
         bus.src_val_valid = 1'b1;
         bus.src_val_keep  = (b == nbeats - 1) ? last_keep : {NE{1'b1}};
         bus.src_val_last  = (b == nbeats - 1);
         #1;
         if (b == 0) chk("first_val_gated_through", 32'(bus.dict_val_valid), 1);
         tick();
      end
      bus.src_val_valid = 1'b0;
      bus.src_val_last  = 1'b0;
   endtask

   task automatic send_id(input logic last);
      int waited;
      waited = 0;
      bus.src_id_valid = 1'b1;
      bus.src_id_last  = last;
      #1;
      while (!bus.src_id_ready && waited < 20) begin
         tick();
         #1;
         waited++;
      end
      chk("id_accept_in_time", 32'(waited < 20), 1);
      tick();
      bus.src_id_valid = 1'b0;
      bus.src_id_last  = 1'b0;
   endtask

   task automatic send_res(input logic last);
      bus.res_valid = 1'b1;
      bus.res_ready = 1'b1;
      bus.res_last  = last;
      tick();
      bus.res_valid = 1'b0;
      bus.res_last  = 1'b0;
   endtask

   task automatic finish_job(input string tag, input exp_t e);
      exp_q.push_back(e);
      send_res(1'b1);
      chk({tag, "_done_pulse"}, 32'(done), 1);
      chk({tag, "_cfg_ready_on_done"}, 32'(bus.cfg_ready), 1);
      check_pop(tag);
      tick();
      chk({tag, "_done_one_cycle"}, 32'(done), 0);
   endtask

   initial begin
      int accepted;
      rst                = 1'b1;
      bus.cfg_valid      = 1'b0;
      bus.cfg_num_values = '0;
      bus.cfg_reload     = 1'b0;
      bus.src_val_valid  = 1'b1;
      bus.src_val_keep   = '1;
      bus.src_val_last   = 1'b0;
      bus.dict_val_ready = 1'b1;
      bus.src_id_valid   = 1'b1;
      bus.src_id_last    = 1'b0;
      bus.dict_id_ready  = 1'b1;
      bus.res_valid      = 1'b0;
      bus.res_ready      = 1'b1;
      bus.res_last       = 1'b0;

      // Reset: sources offer data but every gate must stay closed.
      tick();
      tick();
      #1;
      exp_q.push_back('{st: 0, cnt: 0, errc: 0, ovf: 0, und: 0});
      check_pop("reset");
      chk("reset_done",           32'(done), 0);
      chk("reset_cfg_ready",      32'(bus.cfg_ready), 1);
      chk("reset_dict_val_valid", 32'(bus.dict_val_valid), 0);
      chk("reset_src_val_ready",  32'(bus.src_val_ready), 0);
      chk("reset_dict_id_valid",  32'(bus.dict_id_valid), 0);
      chk("reset_src_id_ready",   32'(bus.src_id_ready), 0);
      rst               = 1'b0;
      bus.src_val_valid = 1'b0;
      bus.src_id_valid  = 1'b0;
      tick();

      // Job 1: load 20 values, probe 5 ids with one result per id.
      do_cfg(20, 1'b1);
      chk("job1_state_load", 32'(state), 1);
      exp_q.push_back('{st: 2, cnt: 20, errc: 0, ovf: 0, und: 0});
      load_beats(3, 8'h0F);
      check_pop("job1_load");
      for (int i = 0; i < 4; i++) begin
         send_id(1'b0);
         send_res(1'b0);
      end
      send_id(1'b1);
      chk("job1_state_drain", 32'(state), 3);
      finish_job("job1_end", '{st: EXIT_ST, cnt: 20, errc: 0, ovf: 0, und: 0});

      // Probe-only job.
      do_cfg(0, 1'b0);
`ifdef DICT_SEQ_REPROBE_EN
      exp_q.push_back('{st: 2, cnt: 20, errc: 0, ovf: 0, und: 0});
      check_pop("reprobe");
      send_id(1'b1);
      finish_job("reprobe_end", '{st: 4, cnt: 20, errc: 0, ovf: 0, und: 0});
`else
      exp_q.push_back('{st: 0, cnt: 20, errc: 1, ovf: 0, und: 0});
      check_pop("reprobe_rejected");
      tick();
      chk("reprobe_stays_idle", 32'(state), 0);
`endif

      // Job 2: count mismatch, then credit limit with results held off.
      do_cfg(24, 1'b1);
      exp_q.push_back('{st: 2, cnt: 20, errc: 1, ovf: 0, und: 0});
      load_beats(3, 8'h0F);
      check_pop("job2_load");
      accepted = 0;
      bus.src_id_valid = 1'b1;
      bus.src_id_last  = 1'b0;
      for (int i = 0; i < 6; i++) begin
         #1;
         if (bus.src_id_ready) accepted++;
         tick();
      end
      chk("credit_accepted", 32'(accepted), 4);
      #1;
      chk("credit_blocked_ready", 32'(bus.src_id_ready), 0);
      chk("credit_blocked_valid", 32'(bus.dict_id_valid), 0);
      bus.src_id_valid = 1'b0;
      send_res(1'b0);
      #1;
      chk("credit_returned_ready", 32'(bus.src_id_ready), 1);
      send_id(1'b1);
      for (int i = 0; i < 3; i++) send_res(1'b0);
      finish_job("job2_end", '{st: EXIT_ST, cnt: 20, errc: 1, ovf: 0, und: 0});

      // Job 3: overflow saturates, stray result flags underrun.
      do_cfg(32, 1'b1);
      exp_q.push_back('{st: 2, cnt: 32, errc: 0, ovf: 1, und: 0});
      load_beats(5, 8'hFF);
      check_pop("job3_load");
      send_res(1'b0);
      chk("underrun_flag", 32'(err_underrun), 1);
      send_id(1'b1);
      finish_job("job3_end", '{st: EXIT_ST, cnt: 32, errc: 0, ovf: 1, und: 1});

      // Reset in the middle of a load.
      do_cfg(20, 1'b1);
      bus.src_val_valid = 1'b1;
      bus.src_val_keep  = 8'hFF;
      bus.src_val_last  = 1'b0;
      tick();
      chk("midload_count", 32'(loaded_count), 8);
      rst = 1'b1;
      tick();
      #1;
      chk("midload_rst_state",          32'(state), 0);
      chk("midload_rst_loaded_count",   32'(loaded_count), 0);
      chk("midload_rst_dict_val_valid", 32'(bus.dict_val_valid), 0);
      rst               = 1'b0;
      bus.src_val_valid = 1'b0;
      tick();

      chk("scoreboard_drained", 32'(exp_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dictionary_sequencer.md
# dictionary_sequencer

Phase controller that sits in front of the dictionary datapath and sequences its two phases: value load, then id probe. It gates the value and id handshakes so only the active phase reaches the datapath, and counts the loaded values against a configured total. It watches the result stream to detect when the probe has drained, and reports status and sticky errors to the control plane. Data buses bypass this block; only valid/ready/keep/last pass through it.

## Interface
- `NUM_ELEMENTS`, default 8: lanes per beat on the value, id and result streams.
- `MAX_ENTRIES`, default 4096: dictionary capacity in values. `CNT_W = $clog2(MAX_ENTRIES+1)`.
- `MAX_IN_TRANSIT`, default 64: maximum number of id beats outstanding in the datapath.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `cfg_valid`, `cfg_ready` in/out 1: job-start handshake.
- `cfg_num_values` in CNT_W: number of values to load.
- `cfg_reload` in 1: 1 means run the load phase; 0 means probe only (requires the reprobe feature).
- `src_val_valid`, `src_val_ready` in/out 1: value-source handshake.
- `src_val_keep` in NUM_ELEMENTS: value-source lane keep.
- `src_val_last` in 1: value-source last beat.
- `dict_val_valid`, `dict_val_ready` out/in 1: gated value handshake toward the datapath.
- `src_id_valid`, `src_id_ready` in/out 1: id-source handshake.
- `src_id_last` in 1: id-source last beat.
- `dict_id_valid`, `dict_id_ready` out/in 1: gated id handshake toward the datapath.
- `res_valid`, `res_ready` in 1: result-stream handshake, monitored only.
- `res_last` in 1: result-stream last beat, monitored only.
- `state` out 3: current FSM state encoding.
- `loaded_count` out CNT_W: values accepted in the last load.
- `done` out 1: one-cycle pulse at job completion.
- `err_count`, `err_overflow`, `err_underrun` out 1: sticky error flags, cleared by the next accepted cfg.

## Operation
- FSM states: IDLE=0, LOAD=1, PROBE=2, DRAIN=3, LOADED=4.
- IDLE / LOADED:
  - `cfg_ready=1`.
  - On a cfg handshake with `cfg_reload=1`: clear `loaded_count` and the error flags, latch `cfg_num_values`, go to LOAD.
  - On a cfg handshake with `cfg_reload=0` in LOADED: go to PROBE.
  - On a cfg handshake with `cfg_reload=0` in IDLE: set `err_count`, stay in IDLE.
- LOAD:
  - `dict_val_valid = src_val_valid`, `src_val_ready = dict_val_ready`; all other gates are 0.
  - Each accepted beat adds `popcount(src_val_keep)` to `loaded_count`, saturating at MAX_ENTRIES.
  - If the sum would exceed MAX_ENTRIES, set `err_overflow`.
  - On an accepted beat with `src_val_last`, go to PROBE. The final count includes that beat.
  - If the final count is not equal to the latched `cfg_num_values`, set `err_count`.
- PROBE:
  - `dict_id_valid = src_id_valid && (outstanding < MAX_IN_TRANSIT)`.
  - `src_id_ready = dict_id_ready && (outstanding < MAX_IN_TRANSIT)`.
  - The `outstanding` counter is incremented per accepted id beat and decremented per accepted result beat. Both in the same cycle leaves it unchanged.
  - On an accepted id beat with `src_id_last`, go to DRAIN.
- DRAIN:
  - All gates are 0.
  - On a result handshake with `res_last`: pulse `done`, then go to LOADED (IDLE when the reprobe feature is compiled out).
  - `outstanding` must be 0 after that beat; otherwise set `err_count`.
- A result handshake while `outstanding==0` sets `err_underrun`; the counter stays at 0.
- A result `last` in PROBE on the same cycle as the id `last` acceptance goes directly to the DRAIN exit.
- Values are never accepted outside LOAD, and ids never outside PROBE.

## Timing
- Gating is combinational: zero added latency, no register stage on any valid or ready.
- State, counters and flags update on the `clk` edge following the handshake.
- The first LOAD beat can be accepted the cycle after the cfg handshake.
- The first PROBE id can be accepted the cycle after the value `last`.
- Reset values: `state`=IDLE, `loaded_count`=0, `outstanding`=0, `done`=0, all error flags 0.
- Reset values of the outputs: `cfg_ready=1`; all `dict_*_valid` and `src_*_ready` are 0.
- Reset mid-job returns to IDLE immediately, regardless of in-flight beats. The datapath must be reset on the same cycle.
- `done` is high for exactly one cycle. `cfg_ready` is asserted again on the cycle `done` is high.

## Configuration
- `DICT_SEQ_REPROBE_EN` defined:
  - After DRAIN the FSM enters LOADED.
  - Repeated probe jobs with `cfg_reload=0` reuse the loaded contents.
- `DICT_SEQ_REPROBE_EN` undefined:
  - LOADED is unreachable; DRAIN exits to IDLE.
  - Every job must reload.
  - `cfg_reload=0` sets `err_count` and is otherwise ignored.

## Test plan
- Single load:
  - Stimulus: cfg 20 values (`NUM_ELEMENTS=8`); 3 beats with keep 0xFF, 0xFF, 0x0F, last on beat 3.
  - Required: `loaded_count=20`, no errors, PROBE on the next cycle.
- Count mismatch:
  - Stimulus: cfg 24, load only 20.
  - Required: `err_count=1`, FSM still proceeds to PROBE.
- Credit limit:
  - Stimulus: `MAX_IN_TRANSIT=4`, `res_valid` held at 0, 6 id beats offered.
  - Required: exactly 4 accepted, then `src_id_ready=0` until one result is accepted.
- Drain and done:
  - Stimulus: ids with last on beat 5; 5 results returned with last on the 5th.
  - Required: single-cycle `done`; `state` becomes LOADED (macro on) or IDLE (macro off).
- Reprobe:
  - Stimulus: macro on, second cfg with `cfg_reload=0`.
  - Required: PROBE directly, `loaded_count` unchanged.
  - Stimulus: macro off, same cfg.
  - Required: `err_count=1`, `state` stays IDLE.
- Reset mid-LOAD:
  - Stimulus: assert `rst` after 1 beat.
  - Required: `state`=IDLE, `loaded_count=0`, `dict_val_valid=0` on the next cycle.
